// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a decoupling prefetch queue.
// Owns the PC, issues sequential fetches to a one-cycle-latency memory and buffers
// {pc, instr} pairs in a DEPTH-entry FIFO presented to decode via valid/ready.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic issue;
    logic push;
    logic pop;

    // Handshake decode; the issue rule reserves a FIFO slot for every in-flight word.
    always_comb begin
        issue     = reset && !redirect_valid &&
                    ((count_q + CW'(inflight_q)) < CW'(DEPTH));
        push      = inflight_q && !redirect_valid;
        out_valid = (count_q != '0) && !redirect_valid;
        pop       = out_valid && out_ready;
        imem_req  = issue;
        imem_addr = fetch_pc_q;
        out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
        out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
        occupancy = count_q;
    end

    // Next-state logic; a redirect overrides issue, response and pop in its cycle.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + XLEN'(4);
                inflight_pc_d = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue. It owns the program counter and issues sequential fetches to a fixed one-cycle-latency instruction memory port. Returned words are buffered with their PCs in a DEPTH-entry FIFO, which is presented to decode through a valid/ready handshake. A redirect from a later stage flushes all wrong-path state and restarts fetch at the target, so this block replaces the single IF/ID register with elastic buffering.

## Interface
- XLEN, 32: PC and instruction width in bits.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 0: first fetch address after reset.
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request this cycle; the memory always accepts it.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_rdata  in  XLEN  instruction for the request accepted in the previous cycle.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  XLEN  PC of the head entry; 0 when out_valid=0.
- out_instr  out  XLEN  instruction of the head entry; 0 when out_valid=0.
- occupancy  out  $clog2(DEPTH)+1  number of valid queue entries.

## Operation
- State:
  - fetch_pc register.
  - inflight flag, plus the PC of the in-flight request.
  - FIFO of {pc, instr} with rd_ptr and wr_ptr (log2 DEPTH bits, wrapping).
  - count register, 0..DEPTH.
- Issue rule: imem_req = (count + inflight < DEPTH) and not redirect_valid.
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += 4, modulo 2^XLEN, so 0xFFFFFFFC wraps to 0. Set inflight and record the PC.
- Response:
  - If inflight is set in the cycle after an issue, capture imem_rdata with the recorded PC into FIFO[wr_ptr].
  - Advance wr_ptr.
  - Clear inflight unless a new request is issued in the same cycle.
- Pop: out_valid = (count != 0) and not redirect_valid. When out_valid and out_ready, advance rd_ptr.
- Push and pop in the same cycle: count is unchanged. This is legal at count=DEPTH because the issue rule reserves a slot for every in-flight word, so the FIFO can never overflow.
- Redirect (redirect_valid=1) takes priority over everything else in that cycle:
  - No issue and no pop; out_valid is forced to 0 combinationally.
  - A response arriving in this cycle is discarded.
  - count, rd_ptr and wr_ptr are cleared to 0, and inflight is cleared.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
- Consecutive redirect cycles: the last target wins, and no requests are issued until redirect_valid falls.
- occupancy = count, a registered value.

## Timing
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC.
  - count=0, both pointers 0, inflight=0.
  - imem_req=0, out_valid=0, out_pc=0, out_instr=0, occupancy=0.
  - FIFO storage does not need to be reset.
- Reset mid-operation: all state returns to the reset values immediately, regardless of any in-flight request or queued entries.
- Cold start: reset is released before edge E0.
  - Cycle C0: imem_req=1, imem_addr=RESET_PC.
  - Cycle C1: data arrives and is written at the end of C1.
  - Cycle C2: out_valid=1 with out_pc=RESET_PC.
- Fetch-to-decode latency is 2 cycles.
- Redirect asserted in cycle T:
  - T+1: imem_req with imem_addr = target.
  - T+3: out_valid with out_pc = target.
- Redirect penalty is 3 cycles from redirect to the first valid target instruction.
- Steady state with out_ready=1: one instruction per cycle, count ≤ 1.
- With out_ready=0 the queue fills. Requests stop once count + inflight = DEPTH, after exactly DEPTH issued requests.
- out_pc and out_instr change only on the clock edge, apart from the combinational zero-forcing during a redirect cycle.

## Test plan
- Cold stream: RESET_PC=0x100, out_ready=1 held for 8 cycles.
  - Required: imem_addr 0x100, 0x104, ... on consecutive cycles.
  - Required: first out_valid at C2 with pc 0x100, then one entry per cycle in order, with out_instr equal to the memory model's word for each PC.
- Backpressure: DEPTH=4, out_ready=0 for 10 cycles, then 1.
  - Required: exactly 4 requests issued and occupancy saturates at 4.
  - Required: no overflow and no lost word; on release, 4 back-to-back pops in PC order, then fetch resumes at base+16.
- Redirect while full and with a request in flight: redirect_pc=0x2002.
  - Required: the stale response is dropped and occupancy becomes 0 next cycle.
  - Required: imem_addr=0x2000 at T+1 and out_pc=0x2000 at T+3, with no wrong-path entry ever valid.
- Redirect held for 3 cycles with targets 0x40, 0x80, 0xC0.
  - Required: imem_req=0 throughout.
  - Required: the first request after release is to 0xC0.
- PC wrap: redirect to 0xFFFFFFF8.
  - Required: fetches are issued to 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 in that order.
- Async reset mid-stream: reset pulled low between edges while count=3.
  - Required: out_valid=0 and occupancy=0 immediately, imem_req=0.
  - Required: after release, restart at RESET_PC with the C0/C2 timing above.
